// File: rtl/dfr0520_spi_slave_pkg.sv
// rtl/dfr0520_spi_slave_pkg.sv - shared command codes, frame layout and FSM types for the DFR0520 pot link
package dfr0520_spi_slave_pkg;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_SHDN  = 2'b10;

  localparam int FRAME_LEN = 16;
  localparam int CMD_LSB   = 12;
  localparam int SEL_LSB   = 8;
  localparam int DATA_LSB  = 0;

  // Bits 15:14 never need storing; they fall off the top of a 14-bit shifter.
  localparam int SHREG_W = CMD_LSB + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  typedef struct packed {
    logic [1:0] cmd;
    logic [1:0] sel;
    logic [7:0] data;
  } frame_t;

  function automatic frame_t unpack_frame(input logic [SHREG_W-1:0] w);
    frame_t f;
    f.cmd  = w[CMD_LSB+1:CMD_LSB];
    f.sel  = w[SEL_LSB+1:SEL_LSB];
    f.data = w[DATA_LSB+7:DATA_LSB];
    return f;
  endfunction

endpackage

// File: rtl/dfr0520_spi_slave_if.sv
// rtl/dfr0520_spi_slave_if.sv - SPI pin bundle between pot-command master and responder
interface dfr0520_spi_slave_if;
  logic CS;
  logic SCK;
  logic MOSI;

  modport master (output CS, output SCK, output MOSI);
  modport slave  (input CS, input SCK, input MOSI);
endinterface

// File: rtl/dfr0520_sync.sv
// rtl/dfr0520_sync.sv - multi-flop synchroniser with selectable reset value
module dfr0520_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {STAGES{RESET_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/dfr0520_spi_slave.sv
// rtl/dfr0520_spi_slave.sv - oversampled SPI responder decoding DFR0520 frames into wiper/shutdown registers
module dfr0520_spi_slave
  import dfr0520_spi_slave_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_WIPER = 8'h80,
  parameter int         FRAME_BITS  = FRAME_LEN
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  dfr0520_spi_slave_if.slave   spi,
  output logic [7:0]           wiper0,
  output logic [7:0]           wiper1,
  output logic [1:0]           shdn,
  output logic                 frame_valid,
  output logic [1:0]           frame_cmd,
  output logic [1:0]           frame_sel,
  output logic [7:0]           frame_data,
  output logic                 frame_err
);

  localparam int                 CNT_W   = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]   CNT_OK  = CNT_W'(FRAME_BITS);

  logic cs_s, sck_s, mosi_s;

  dfr0520_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk_in), .rst_n(rst_n), .d(spi.CS), .q(cs_s)
  );
  dfr0520_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk_in), .rst_n(rst_n), .d(spi.SCK), .q(sck_s)
  );
  dfr0520_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk_in), .rst_n(rst_n), .d(spi.MOSI), .q(mosi_s)
  );

  // Edge pulses are registered; mosi_q and cs_q are delayed alongside so all
  // FSM inputs describe the same pin instant.
  logic cs_q, sck_q, mosi_q;
  logic cs_rise, sck_rise;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cs_rise  <= 1'b0;
      sck_rise <= 1'b0;
    end else begin
      cs_q     <= cs_s;
      sck_q    <= sck_s;
      mosi_q   <= mosi_s;
      cs_rise  <= cs_s & ~cs_q;
      sck_rise <= sck_s & ~sck_q;
    end
  end

  state_t             state;
  logic [SHREG_W-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;
  frame_t             fr;

  assign fr = unpack_frame(shreg);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      wiper0      <= RESET_WIPER;
      wiper1      <= RESET_WIPER;
      shdn        <= 2'b00;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cmd   <= 2'b00;
      frame_sel   <= 2'b00;
      frame_data  <= 8'h00;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!cs_q) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          // A CS rise wins over a coincident SCK edge.
          if (cs_rise) begin
            state <= ST_COMMIT;
          end else if (sck_rise) begin
            shreg <= {shreg[SHREG_W-2:0], mosi_q};
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          if (bit_cnt == CNT_OK) begin
            frame_valid <= 1'b1;
            frame_cmd   <= fr.cmd;
            frame_sel   <= fr.sel;
            frame_data  <= fr.data;
            if (fr.cmd == CMD_WRITE) begin
              if (fr.sel[0]) begin
                wiper0  <= fr.data;
                shdn[0] <= 1'b0;
              end
              if (fr.sel[1]) begin
                wiper1  <= fr.data;
                shdn[1] <= 1'b0;
              end
            end else if (fr.cmd == CMD_SHDN) begin
              shdn <= shdn | fr.sel;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfr0520_spi_slave.sv
// tb/tb_dfr0520_spi_slave.sv - directed self-checking bench for dfr0520_spi_slave
module tb_dfr0520_spi_slave;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] wiper0, wiper1, frame_data;
  logic [1:0] shdn, frame_cmd, frame_sel;
  logic       frame_valid, frame_err;

  dfr0520_spi_slave_if spi ();

  dfr0520_spi_slave #(.SYNC_STAGES(2), .RESET_WIPER(8'h80), .FRAME_BITS(16)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .spi(spi.slave),
    .wiper0(wiper0), .wiper1(wiper1), .shdn(shdn),
    .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_sel(frame_sel),
    .frame_data(frame_data), .frame_err(frame_err)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int cs_up[$];
  int valid_cyc[$];
  logic [7:0] valid_data[$];

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (frame_valid === 1'b1) begin
      valid_cnt++;
      valid_cyc.push_back(cyc);
      valid_data.push_back(frame_data);
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // SCK runs at clk_in/4: two clk_in cycles per half period.
  task automatic send_bits(input logic [31:0] word, input int n);
    spi.CS = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      spi.MOSI = word[i];
      tick(2);
      spi.SCK = 1'b1;
      tick(2);
      spi.SCK = 1'b0;
    end
    tick(2);
    spi.CS = 1'b1;
    cs_up.push_back(cyc);
  endtask

  task automatic send_frame(input logic [15:0] w);
    send_bits({16'h0000, w}, 16);
    tick(12);
  endtask

  task automatic test_reset;
    spi.CS = 1'b1; spi.SCK = 1'b0; spi.MOSI = 1'b0;
    rst_n = 1'b0;
    tick(3);
    vectors++; if (wiper0 !== 8'h80) begin miscompares++; $display("FAIL reset_wiper0 got %h want 80", wiper0); end
    vectors++; if (wiper1 !== 8'h80) begin miscompares++; $display("FAIL reset_wiper1 got %h want 80", wiper1); end
    vectors++; if (shdn !== 2'b00) begin miscompares++; $display("FAIL reset_shdn got %b want 00", shdn); end
    vectors++; if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got %b%b want 00", frame_valid, frame_err); end
    vectors++; if ({frame_cmd, frame_sel, frame_data} !== 12'h000) begin miscompares++; $display("FAIL reset_fields got %h want 000", {frame_cmd, frame_sel, frame_data}); end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_write_single;
    int v0;
    v0 = valid_cnt;
    send_frame(16'h11A5);
    vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL write1_valid_count got %0d want 1", valid_cnt - v0); end
    vectors++; if (wiper0 !== 8'hA5) begin miscompares++; $display("FAIL write1_wiper0 got %h want a5", wiper0); end
    vectors++; if (wiper1 !== 8'h80) begin miscompares++; $display("FAIL write1_wiper1 got %h want 80", wiper1); end
    vectors++; if (frame_cmd !== 2'b01 || frame_sel !== 2'b01) begin miscompares++; $display("FAIL write1_cmd_sel got %b %b want 01 01", frame_cmd, frame_sel); end
    vectors++; if (frame_data !== 8'hA5) begin miscompares++; $display("FAIL write1_data got %h want a5", frame_data); end
  endtask

  task automatic test_write_after_shutdown;
    send_frame(16'h2300);
    vectors++; if (shdn !== 2'b11) begin miscompares++; $display("FAIL shdn_both got %b want 11", shdn); end
    vectors++; if (wiper0 !== 8'hA5) begin miscompares++; $display("FAIL shdn_both_wiper0 got %h want a5", wiper0); end
    send_frame(16'h133C);
    vectors++; if (wiper0 !== 8'h3C || wiper1 !== 8'h3C) begin miscompares++; $display("FAIL write_both got %h %h want 3c 3c", wiper0, wiper1); end
    vectors++; if (shdn !== 2'b00) begin miscompares++; $display("FAIL write_both_shdn got %b want 00", shdn); end
  endtask

  task automatic test_shutdown;
    int v0;
    v0 = valid_cnt;
    send_frame(16'h2200);
    vectors++; if (shdn !== 2'b10) begin miscompares++; $display("FAIL shdn1 got %b want 10", shdn); end
    vectors++; if (wiper0 !== 8'h3C || wiper1 !== 8'h3C) begin miscompares++; $display("FAIL shdn1_wipers got %h %h want 3c 3c", wiper0, wiper1); end
    vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL shdn1_valid_count got %0d want 1", valid_cnt - v0); end
  endtask

  task automatic test_bad_length;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(32'h0000_1155, 12);
    tick(12);
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL short_err_count got %0d want 1", err_cnt - e0); end
    send_bits(32'h000F_1155, 20);
    tick(12);
    vectors++; if (err_cnt - e0 !== 2) begin miscompares++; $display("FAIL long_err_count got %0d want 2", err_cnt - e0); end
    vectors++; if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL badlen_valid_count got %0d want 0", valid_cnt - v0); end
    vectors++; if ({wiper0, wiper1, shdn} !== {8'h3C, 8'h3C, 2'b10}) begin miscompares++; $display("FAIL badlen_regs got %h %h %b want 3c 3c 10", wiper0, wiper1, shdn); end
    vectors++; if ({frame_cmd, frame_sel, frame_data} !== {2'b10, 2'b10, 8'h00}) begin miscompares++; $display("FAIL badlen_fields got %h want a00", {frame_cmd, frame_sel, frame_data}); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    spi.CS = 1'b0;
    tick(4);
    for (int i = 7; i >= 0; i--) begin
      spi.MOSI = i[0];
      tick(2);
      spi.SCK = 1'b1;
      tick(2);
      spi.SCK = 1'b0;
    end
    rst_n = 1'b0;
    tick(3);
    spi.CS = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(8);
    vectors++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL midrst_pulses got %0d %0d want 0 0", valid_cnt - v0, err_cnt - e0); end
    vectors++; if ({wiper0, wiper1, shdn} !== {8'h80, 8'h80, 2'b00}) begin miscompares++; $display("FAIL midrst_regs got %h %h %b want 80 80 00", wiper0, wiper1, shdn); end
    send_frame(16'h1155);
    vectors++; if (wiper0 !== 8'h55 || wiper1 !== 8'h80) begin miscompares++; $display("FAIL midrst_write got %h %h want 55 80", wiper0, wiper1); end
    vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL midrst_valid_count got %0d want 1", valid_cnt - v0); end
  endtask

  task automatic test_back_to_back;
    cs_up.delete(); valid_cyc.delete(); valid_data.delete();
    send_bits(32'h0000_1177, 16);
    tick(4);
    send_bits(32'h0000_1288, 16);
    tick(12);
    vectors++;
    if (valid_cyc.size() !== 2) begin
      miscompares++; $display("FAIL b2b_count got %0d want 2", valid_cyc.size());
    end else begin
      vectors++; if (valid_data[0] !== 8'h77 || valid_data[1] !== 8'h88) begin miscompares++; $display("FAIL b2b_order got %h %h want 77 88", valid_data[0], valid_data[1]); end
      // CS raised at a negedge with cyc=N; first sampling edge is N+1, update at N+1+SYNC_STAGES+2.
      for (int k = 0; k < 2; k++) begin
        vectors++; if (valid_cyc[k] - cs_up[k] !== 5) begin miscompares++; $display("FAIL b2b_latency%0d got %0d want 5", k, valid_cyc[k] - cs_up[k]); end
      end
    end
    vectors++; if (wiper0 !== 8'h77 || wiper1 !== 8'h88) begin miscompares++; $display("FAIL b2b_wipers got %h %h want 77 88", wiper0, wiper1); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_write_after_shutdown();
    test_shutdown();
    test_bad_length();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
